// File: rtl/sd_cmd_issue_ctrl.sv
// sd_cmd_issue_ctrl: formats SD commands and runs the command/response handshakes with
// sd_cmd_serial_host under a response timeout. Option macro: SD_CMD_BUSY_WAIT_EN (DAT0 busy wait).
module sd_cmd_issue_ctrl #(
   parameter int TIMEOUT_W = 16,
   parameter int RSP_W     = 40
) (
   input  logic                 SD_CLK_IN,
   input  logic                 RST_IN,
   input  logic                 start_i,
   input  logic [5:0]           cmd_idx_i,
   input  logic [31:0]          arg_i,
   input  logic [1:0]           rsp_type_i,
   input  logic                 crc_chk_i,
   input  logic                 idx_chk_i,
   input  logic [TIMEOUT_W-1:0] timeout_i,
   output logic [39:0]          CMD_OUT_o,
   output logic [15:0]          SETTING_OUT,
   output logic                 REQ_OUT,
   input  logic                 ACK_IN,
   input  logic                 RSP_REQ_IN,
   output logic                 RSP_ACK_OUT,
   input  logic [RSP_W-1:0]     RSP_IN,
   input  logic [7:0]           STATUS_IN,
   input  logic                 dat0_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [3:0]           err_o,
   output logic [RSP_W-1:0]     rsp_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT_RSP,
      S_RSP_ACK,
      S_BUSY,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [39:0]          cmd_q, cmd_d;
   logic [15:0]          set_q, set_d;
   logic                 req_q, req_d;
   logic                 rack_q, rack_d;
   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
   logic [3:0]           err_q, err_d;
   logic [RSP_W-1:0]     rsp_q, rsp_d;

   logic                 tmo_en;
   logic                 expired;
   logic [TIMEOUT_W-1:0] cnt_inc;
   logic                 unused_status;

`ifdef SD_CMD_BUSY_WAIT_EN
   logic hi_q, hi_d;
   logic busy_wait;
   assign busy_wait = (set_q[1:0] == 2'b11);
`else
   logic unused_dat0;
   assign unused_dat0 = dat0_i;
`endif

   assign unused_status = ^{STATUS_IN[7:3], STATUS_IN[0]};

   // A zero timeout disables expiry; the counter then simply holds.
   assign tmo_en  = (timeout_i != '0);
   assign expired = tmo_en && (cnt_q == timeout_i - TIMEOUT_W'(1));
   assign cnt_inc = cnt_q + TIMEOUT_W'(1);

   always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         state_q <= S_IDLE;
         cmd_q   <= '0;
         set_q   <= '0;
         req_q   <= 1'b0;
         rack_q  <= 1'b0;
         cnt_q   <= '0;
         err_q   <= '0;
         rsp_q   <= '0;
`ifdef SD_CMD_BUSY_WAIT_EN
         hi_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         set_q   <= set_d;
         req_q   <= req_d;
         rack_q  <= rack_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rsp_q   <= rsp_d;
`ifdef SD_CMD_BUSY_WAIT_EN
         hi_q    <= hi_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      set_d   = set_q;
      req_d   = req_q;
      rack_d  = rack_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      rsp_d   = rsp_q;
`ifdef SD_CMD_BUSY_WAIT_EN
      hi_d    = hi_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               cmd_d   = {2'b01, cmd_idx_i, arg_i};
               set_d   = {12'h000, idx_chk_i, crc_chk_i, rsp_type_i};
               err_d   = '0;
               req_d   = !ACK_IN;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            // REQ is only raised once the previous ACK has been released.
            if (req_q && ACK_IN) begin
               req_d   = 1'b0;
               cnt_d   = '0;
               state_d = (set_q[1:0] == 2'b00) ? S_DONE : S_WAIT_RSP;
            end else if (!req_q && !ACK_IN) begin
               req_d = 1'b1;
            end
         end
         S_WAIT_RSP: begin
            if (RSP_REQ_IN) begin
               rsp_d    = RSP_IN;
               err_d[1] = STATUS_IN[1] & set_q[2];
               err_d[2] = STATUS_IN[2] & set_q[3];
               rack_d   = 1'b1;
               state_d  = S_RSP_ACK;
            end else if (expired) begin
               err_d[0] = 1'b1;
               state_d  = S_DONE;
            end else if (tmo_en) begin
               cnt_d = cnt_inc;
            end
         end
         S_RSP_ACK: begin
            if (!RSP_REQ_IN) begin
               rack_d  = 1'b0;
               cnt_d   = '0;
`ifdef SD_CMD_BUSY_WAIT_EN
               hi_d    = 1'b0;
               state_d = busy_wait ? S_BUSY : S_DONE;
`else
               state_d = S_DONE;
`endif
            end
         end
         S_BUSY: begin
`ifdef SD_CMD_BUSY_WAIT_EN
            // Card is released after DAT0 is high on two consecutive samples.
            if (dat0_i && hi_q) begin
               state_d = S_DONE;
            end else if (expired) begin
               err_d[3] = 1'b1;
               state_d  = S_DONE;
            end else begin
               hi_d = dat0_i;
               if (tmo_en) begin
                  cnt_d = cnt_inc;
               end
            end
`else
            state_d = S_DONE;
`endif
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      busy_o = (state_q != S_IDLE);
      done_o = (state_q == S_DONE);
   end

   assign CMD_OUT_o   = cmd_q;
   assign SETTING_OUT = set_q;
   assign REQ_OUT     = req_q;
   assign RSP_ACK_OUT = rack_q;
   assign err_o       = err_q;
   assign rsp_o       = rsp_q;

endmodule

// File: doc/sd_cmd_issue_ctrl.md
Name: sd_cmd_issue_ctrl

Overview:
Command-issue controller sitting directly upstream of sd_cmd_serial_host. It accepts a command from the register file, formats the 40-bit command word and 16-bit setting word, and runs the request/acknowledge handshake with the serial host. It then waits for the response under a cycle timeout, captures the response and host status, and reports completion and error flags to the register and interrupt logic.

Parameters:
TIMEOUT_W, 16, width of the response timeout counter and of timeout_i
RSP_W, 40, width of the captured response payload

Ports:
SD_CLK_IN  input  1  SD clock; all logic on rising edge
RST_IN  input  1  asynchronous active-high reset
start_i  input  1  single-cycle pulse: issue command (ignored while busy_o=1)
cmd_idx_i  input  6  command index
arg_i  input  32  command argument
rsp_type_i  input  2  00 none, 01 48-bit, 10 136-bit, 11 48-bit with busy
crc_chk_i  input  1  enable CRC error reporting
idx_chk_i  input  1  enable index error reporting
timeout_i  input  TIMEOUT_W  response timeout in cycles; 0 means no timeout
CMD_OUT_o  output  40  to host CMD_IN: {2'b01, cmd_idx, arg}
SETTING_OUT  output  16  to host SETTING_IN: [1:0]=rsp_type, [2]=crc_chk, [3]=idx_chk, [15:4]=0
REQ_OUT  output  1  to host REQ_IN, command request
ACK_IN  input  1  from host ACK_OUT, command accepted
RSP_REQ_IN  input  1  from host REQ_OUT, response ready
RSP_ACK_OUT  output  1  to host ACK_IN, response consumed
RSP_IN  input  RSP_W  response payload from host
STATUS_IN  input  8  host STATUS: [1] CRC error, [2] index mismatch
dat0_i  input  1  DAT0 level (used by the busy-wait option only)
busy_o  output  1  command in progress
done_o  output  1  one-cycle completion pulse
err_o  output  4  [0] timeout, [1] CRC, [2] index, [3] busy timeout; valid from done_o until next start
rsp_o  output  RSP_W  captured response; held until next capture

Behaviour:
- Reset (asynchronous, RST_IN=1): state IDLE. All outputs 0, including CMD_OUT_o, SETTING_OUT, rsp_o and err_o. The timeout counter is cleared.
- IDLE: on start_i, latch the inputs into CMD_OUT_o and SETTING_OUT, clear err_o, set busy_o and go to REQ. The outputs update on the same edge.
- REQ: REQ_OUT=1. When ACK_IN=1, drop REQ_OUT.
  - If rsp_type=00, go to DONE.
  - Otherwise clear the counter and go to WAIT_RSP.
- WAIT_RSP: the counter increments each cycle while timeout_i!=0.
  - On RSP_REQ_IN=1: capture rsp_o<=RSP_IN. Set err_o[1]=STATUS_IN[1]&crc_chk and err_o[2]=STATUS_IN[2]&idx_chk. Assert RSP_ACK_OUT and go to RSP_ACK.
  - If the counter reaches timeout_i-1 with no RSP_REQ_IN: set err_o[0] and go to DONE.
  - If RSP_REQ_IN and expiry fall on the same cycle, the response wins.
- RSP_ACK: hold RSP_ACK_OUT=1 until RSP_REQ_IN=0, then drop it. The next state is BUSY if rsp_type=11 and the option is compiled in, otherwise DONE.
- DONE: one cycle. done_o=1, busy_o=0 on exit, return to IDLE.
- REQ_OUT and RSP_ACK_OUT are registered. They are never high simultaneously.
- Handshake: 4-phase. REQ_OUT is not reasserted until ACK_IN has been seen low in IDLE.
- start_i while busy_o=1: ignored, no error.
- Latency: a rsp_type=00 command with a host that acks in 1 cycle gives start to done_o in 3 cycles.

Optional Feature:
SD_CMD_BUSY_WAIT_EN
- Defined: rsp_type=11 enters BUSY after RSP_ACK. The block waits for dat0_i=1 for 2 consecutive cycles, then goes to DONE. The wait uses the same timeout_i counter, restarted on entry; expiry sets err_o[3] and goes to DONE.
- Undefined: rsp_type=11 behaves as 01, err_o[3] is tied 0, and dat0_i is unused.

Test Plan:
- start, idx=0, arg=0, rsp_type=00; host ACK_IN after 2 cycles -> CMD_OUT_o=40'h40_0000_0000, SETTING_OUT=16'h0000, done_o pulse, err_o=0, no RSP_ACK_OUT.
- idx=17, arg=32'h0000_0200, rsp_type=01, crc+idx chk; host returns RSP_IN=40'h11_0000_0900, STATUS_IN=0 -> CMD_OUT_o=40'h51_0000_0200, SETTING_OUT=16'h000D, rsp_o=40'h11_0000_0900, err_o=0.
- rsp_type=01, timeout_i=20, host never raises RSP_REQ_IN -> done_o exactly 20 cycles after entering WAIT_RSP, err_o=4'b0001, rsp_o unchanged.
- Response with STATUS_IN=8'h06, crc_chk=1, idx_chk=0 -> err_o=4'b0010; RSP_ACK_OUT stays high until RSP_REQ_IN falls.
- RST_IN pulsed while in WAIT_RSP -> all outputs 0 immediately. A following start_i is serviced normally.
- With SD_CMD_BUSY_WAIT_EN, rsp_type=11, dat0_i low 10 cycles then high -> done_o 2 cycles after rise, err_o=0. With dat0_i stuck low and timeout_i=8 -> err_o[3]=1.
